// File: rtl/md_hilo_unit.sv
// Multiply/divide unit with HI/LO registers for the EX stage.
// Also provides the move-from result select (HI, LO or ALU).
module md_hilo_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] alu_in,
    input  logic [1:0]       movefrom,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] result
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       op_q;

    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] prod;
    logic               neg_a;
    logic               neg_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   uq;
    logic [WIDTH-1:0]   ur;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic [2*WIDTH-1:0] res;
    logic               div_zero;

    // Arithmetic on the latched operands; op_q[0] selects unsigned,
    // op_q[1] selects divide. Signed divide works on magnitudes, so
    // MIN / -1 falls out as quotient MIN, remainder 0.
    always_comb begin
        a_ext    = op_q[0] ? {{WIDTH{1'b0}}, a_q} : {{WIDTH{a_q[WIDTH-1]}}, a_q};
        b_ext    = op_q[0] ? {{WIDTH{1'b0}}, b_q} : {{WIDTH{b_q[WIDTH-1]}}, b_q};
        prod     = a_ext * b_ext;
        neg_a    = ~op_q[0] & a_q[WIDTH-1];
        neg_b    = ~op_q[0] & b_q[WIDTH-1];
        mag_a    = neg_a ? -a_q : a_q;
        mag_b    = neg_b ? -b_q : b_q;
        div_zero = op_q[1] && (b_q == '0);
        uq       = '0;
        ur       = '0;
        if (!div_zero) begin
            uq = mag_a / mag_b;
            ur = mag_a % mag_b;
        end
        quot = (neg_a ^ neg_b) ? -uq : uq;
        rem  = neg_a ? -ur : ur;
        res  = op_q[1] ? {rem, quot} : prod;
    end

    // Issue/run FSM owning HI, LO, busy and the latency counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            count <= '0;
            hi    <= '0;
            lo    <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        unique case (1'b1)
                            !op[2]: begin
                                a_q   <= a;
                                b_q   <= b;
                                op_q  <= op[1:0];
                                count <= op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                                busy  <= 1'b1;
                                state <= RUN;
                            end
                            (op == 3'b100): hi <= a;
                            (op == 3'b101): lo <= a;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (count == CW'(1)) begin
                        if (!div_zero) begin
                            hi <= res[2*WIDTH-1:WIDTH];
                            lo <= res[WIDTH-1:0];
                        end
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Move-from select replacing the plain EX result mux.
    always_comb begin
        unique case (movefrom)
            2'b10:   result = hi;
            2'b01:   result = lo;
            default: result = alu_in;
        endcase
    end

endmodule

// File: tb/tb_md_hilo_unit.sv
// Self-checking bench for md_hilo_unit.
// Timestamp-based reference model plus directed literal checks.
module tb_md_hilo_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] alu_in = '0;
    logic [1:0]  movefrom = 2'b00;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] result;

    md_hilo_unit #(
        .WIDTH(32),
        .MULT_CYCLES(5),
        .DIV_CYCLES(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .op(op),
        .a(a),
        .b(b),
        .alu_in(alu_in),
        .movefrom(movefrom),
        .busy(busy),
        .hi(hi),
        .lo(lo),
        .result(result)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    // {keep, hi, lo}: keep means registers stay unchanged (divide by zero)
    function automatic logic [64:0] model_op(input logic [2:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
        longint          sx = $signed(x);
        longint          sy = $signed(y);
        longint unsigned ux = x;
        longint unsigned uy = y;
        longint          p;
        longint          q;
        longint          r;
        longint unsigned up;
        model_op = '0;
        case (o)
            3'd0: begin
                p = sx * sy;
                model_op = {1'b0, p[63:0]};
            end
            3'd1: begin
                up = ux * uy;
                model_op = {1'b0, up[63:0]};
            end
            3'd2: begin
                if (y == 0) model_op = {1'b1, 64'h0};
                else begin
                    q = sx / sy;
                    r = sx % sy;
                    model_op = {1'b0, r[31:0], q[31:0]};
                end
            end
            default: begin
                if (y == 0) model_op = {1'b1, 64'h0};
                else begin
                    up = ux / uy;
                    p  = longint'(ux % uy);
                    model_op = {1'b0, p[31:0], up[31:0]};
                end
            end
        endcase
    endfunction

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    bit          m_pend = 1'b0;
    int          m_done = 0;
    int          cyc = 0;
    bit          armed = 1'b0;
    logic [64:0] pend_res = '0;

    // Reference model: an accepted op finishes at start edge + latency.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            m_hi   <= '0;
            m_lo   <= '0;
            m_pend <= 1'b0;
            armed  <= 1'b1;
        end else begin
            if (m_pend && (cyc + 1 == m_done)) begin
                if (!pend_res[64]) begin
                    m_hi <= pend_res[63:32];
                    m_lo <= pend_res[31:0];
                end
                m_pend <= 1'b0;
            end
            if (start && !m_pend) begin
                if (!op[2]) begin
                    m_pend   <= 1'b1;
                    m_done   <= cyc + 1 + (op[1] ? 10 : 5);
                    pend_res <= model_op(op, a, b);
                end else if (op == 3'b100) begin
                    m_hi <= a;
                end else if (op == 3'b101) begin
                    m_lo <= a;
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (armed) begin
            check("busy", {63'b0, busy}, {63'b0, m_pend});
            check("hi", {32'b0, hi}, {32'b0, m_hi});
            check("lo", {32'b0, lo}, {32'b0, m_lo});
            check("result", {32'b0, result},
                  {32'b0, (movefrom == 2'b10) ? m_hi : (movefrom == 2'b01) ? m_lo : alu_in});
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(posedge clk);
        #1;
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic count_busy(output int n);
        bit done;
        n = 0;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (busy) n++;
            else done = 1'b1;
        end
        if (!done) check("busy_timeout", 64'd1, 64'd0);
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        check(name, {32'b0, act}, {32'b0, exp});
    endtask

    int n;

    initial begin
        alu_in = 32'h12345678;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        lit("rst_hi", hi, 32'h0);
        lit("rst_lo", lo, 32'h0);
        lit("rst_busy", {31'b0, busy}, 32'h0);
        lit("rst_alu", result, 32'h12345678);

        movefrom = 2'b10;
        issue(3'd0, 32'hFFFFFFFD, 32'd7);
        count_busy(n);
        lit("mult_lat", n, 32'd5);
        lit("mult_hi", result, 32'hFFFFFFFF);
        movefrom = 2'b01;
        #1;
        lit("mult_lo", result, 32'hFFFFFFEB);

        issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        @(posedge clk);
        #1;
        start = 1'b1;
        op = 3'd0;
        a = 32'h1234;
        b = 32'h5678;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~a;
        b = ~b;
        count_busy(n);
        lit("multu_hi", hi, 32'hFFFFFFFE);
        lit("multu_lo", lo, 32'h00000001);
        repeat (7) @(negedge clk);
        lit("ignored_hi", hi, 32'hFFFFFFFE);

        issue(3'd2, 32'hFFFFFFF9, 32'd2);
        count_busy(n);
        lit("div_lat", n, 32'd10);
        lit("div_lo", lo, 32'hFFFFFFFD);
        lit("div_hi", hi, 32'hFFFFFFFF);

        issue(3'd3, 32'd7, 32'd2);
        start = 1'b1;
        op = 3'd2;
        a = 32'h80000000;
        b = 32'hFFFFFFFF;
        count_busy(n);
        lit("divu_lat", n, 32'd10);
        lit("divu_lo", lo, 32'd3);
        lit("divu_hi", hi, 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        count_busy(n);
        lit("b2b_lat", n, 32'd10);
        lit("ovf_lo", lo, 32'h80000000);
        lit("ovf_hi", hi, 32'h0);

        issue(3'd4, 32'hAAAA0000, 32'd0);
        @(negedge clk);
        lit("mthi", hi, 32'hAAAA0000);
        lit("mthi_lo", lo, 32'h80000000);
        issue(3'd5, 32'h0000BBBB, 32'd0);
        @(negedge clk);
        lit("mtlo", lo, 32'h0000BBBB);
        issue(3'd3, 32'd5, 32'd0);
        count_busy(n);
        lit("dz_lat", n, 32'd10);
        lit("dz_hi", hi, 32'hAAAA0000);
        lit("dz_lo", lo, 32'h0000BBBB);

        issue(3'd0, 32'd3, 32'd4);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        lit("abort_busy", {31'b0, busy}, 32'h0);
        lit("abort_hi", hi, 32'h0);
        lit("abort_lo", lo, 32'h0);
        repeat (6) @(negedge clk);
        lit("abort_stays", lo, 32'h0);
        issue(3'd5, 32'h55, 32'd0);
        @(negedge clk);
        lit("mtlo_55", lo, 32'h55);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

endmodule

// File: doc/md_hilo_unit.md
# md_hilo_unit

Parametrised multiply/divide unit with architectural HI/LO registers and the move-from result select, in the EX stage of the MIPS pipeline. It runs multi-cycle MULT/MULTU/DIV/DIVU, single-cycle MTHI/MTLO, and drives a busy flag the hazard unit uses to stall. Its result output replaces the plain combinational EX result select, choosing HI, LO or the ALU result.

## Interface
Parameters:
- WIDTH, 32, datapath width; HI/LO each WIDTH bits, product 2*WIDTH bits
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (>=1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  issue op this cycle
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no effect
- a  in  WIDTH  rs operand / dividend / MT source
- b  in  WIDTH  rt operand / divisor
- alu_in  in  WIDTH  ALU result from EX
- movefrom  in  2  10 select HI, 01 select LO, other select alu_in
- busy  out  1  multi-cycle op in flight
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- result  out  WIDTH  selected EX result

## Operation
- Reset values: hi = 0, lo = 0, busy = 0, counter = 0, FSM in IDLE.
- FSM states: IDLE and RUN.
  - IDLE + start + MULT/MULTU/DIV/DIVU: latch a, b and op; load counter with MULT_CYCLES or DIV_CYCLES; go to RUN.
  - RUN: counter decrements every cycle. When counter reaches 1, write hi/lo, go to IDLE, clear busy.
- MTHI/MTLO with start in IDLE: hi (or lo) = a at that edge. busy stays 0 and the other register is unchanged.
- start while busy = 1: ignored completely. The hazard unit must not issue it.
- MULT: signed WIDTH x WIDTH -> 2*WIDTH product; hi = upper half, lo = lower half.
- MULTU: same, operands unsigned.
- DIV: lo = quotient truncated toward zero; hi = remainder, with the sign of the dividend.
- DIVU: unsigned quotient to lo, remainder to hi.
- Divisor 0 (DIV/DIVU): full latency still elapses; hi/lo are unchanged at completion.
- Signed overflow (most negative / -1): lo = most negative value, hi = 0.
- Results are computed from the latched operands only. Changes on a/b after the start edge have no effect.
- result is combinational:
  - movefrom = 10 → hi
  - movefrom = 01 → lo
  - 00 or 11 → alu_in
- result reflects the current register values, including stale values while busy. Stalling MFHI/MFLO during busy is the hazard unit's job.
- reset mid-operation: abort, busy = 0, hi = lo = 0 at that edge, in-flight result discarded.

## Timing
- busy is registered. For start sampled at edge 0 with a multi-cycle op and latency N:
  - busy = 1 after edge 0 through edge N-1.
  - At edge N: hi/lo update and busy falls.
  - busy is high for exactly N cycles.
- Back-to-back: start may be asserted in the first cycle busy = 0 (edge N+1 at the earliest after the previous start), and is accepted.
- MTHI/MTLO: register visible on hi/lo/result the cycle after the start edge.
- movefrom in the same cycle as start reads the pre-op register value.
- result depends only on current-cycle inputs and registers; zero latency from movefrom/alu_in.

## Test plan
- Reset, then reset held 2 cycles → hi = lo = 0, busy = 0; movefrom = 00 with alu_in = 0x12345678 → result = 0x12345678.
- MULT a = 0xFFFFFFFD, b = 7 → busy high exactly 5 cycles; then hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; movefrom = 10/01 → result equals hi/lo.
- MULTU a = b = 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001. Then start MULT while busy, with a and b toggled mid-op → ignored; final values unchanged.
- DIV a = 0xFFFFFFF9 (-7), b = 2 → after 10 busy cycles lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIVU 7/2 → lo = 3, hi = 1. DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- DIVU a = 5, b = 0 after MTHI 0xAAAA0000 and MTLO 0x0000BBBB → busy 10 cycles; hi/lo stay 0xAAAA0000/0x0000BBBB.
- MULT started, reset asserted on the 3rd busy cycle → next cycle busy = 0, hi = lo = 0. A new MTLO 0x55 afterwards → lo = 0x55 one cycle later.
